acc_spi_responder: RTL and testbench

- SPI mode-0 slave that emulates the ADXL362 accelerometer register interface: command/address/data framing, register file, data-ready interrupt.
- Sits opposite the accelerometer SPI master in system-level benches and FPGA loopback builds, so the glove acquisition path can be exercised without a physical PmodACL2.
- X/Y/Z samples are supplied from fabric. All SPI inputs are oversampled by the system clock.

---
 rtl/acc_spi_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_acc_spi_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_spi_responder.sv
// ADXL362-style SPI mode-0 register responder with sample shadows and DATA_READY interrupt.
// Latency: SPI inputs pass SCLK_SYNC_STAGES flops plus one edge-detect flop; miso updates 1 clk after a detected edge.
// Backpressure: none; the SPI master owns timing, sample_valid is accepted every clk while measuring.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   sclk, chip_select SPI clock (idle low) and active-low select, oversampled by clk
//   mosi, miso        SPI data, MSB first; miso is 0 whenever the frame is not returning read data
//   x_in/y_in/z_in    signed samples, captured on sample_valid while measuring
//   interrupt         registered DATA_READY & INTMAP1[0]
//   measuring         POWER_CTL[1:0] == 2'b10
module acc_spi_responder #(
    parameter int         SCLK_SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD         = 8'hAD,
    parameter logic [7:0] DEVID_MST        = 8'h1D,
    parameter logic [7:0] PARTID           = 8'hF2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               chip_select,
    input  logic               mosi,
    output logic               miso,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic signed [15:0] z_in,
    input  logic               sample_valid,
    output logic               interrupt,
    output logic               measuring
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WR_DATA, ST_RD_DATA, ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [7:0] FILTER_CTL_RST = 8'h13;

    state_t r_state, w_next_state;

    logic [SCLK_SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic        r_sclk_d, r_cs_d;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic [5:0]  r_addr;
    logic        r_is_read, r_tx_sample, r_frame_read, r_srst_pend;
    logic [7:0]  r_regs [0:14];            // 0x20..0x2E
    logic [15:0] r_sx, r_sy, r_sz;         // sample shadows
    logic [15:0] r_fx, r_fy, r_fz;         // per-frame copy for coherent burst reads
    logic        r_data_ready, r_int, r_miso;

    logic       w_sclk_s, w_cs_s, w_mosi_s;
    logic       w_sclk_rise, w_sclk_fall, w_cs_fall;
    logic       w_start, w_active, w_deselect, w_byte_done;
    logic [7:0] w_byte;
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_dat;
    logic       w_rd_is_sample, w_rd_in_rw, w_wr_in_rw;

    assign w_sclk_s    = r_sclk_sync[SCLK_SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SCLK_SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SCLK_SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    assign w_start     = (r_state == ST_IDLE) && w_cs_fall;
    assign w_active    = (r_state != ST_IDLE) && !w_cs_s;
    assign w_deselect  = (r_state != ST_IDLE) && w_cs_s;
    assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_rx, w_mosi_s};

    // During ADDR the register to load is the one being addressed right now.
    assign w_rd_addr      = (r_state == ST_ADDR) ? w_byte[5:0] : r_addr;
    assign w_rd_is_sample = (w_rd_addr >= 6'h0E) && (w_rd_addr <= 6'h13);
    assign w_rd_in_rw     = (w_rd_addr[5:4] == 2'b10) && (w_rd_addr[3:0] != 4'hF);
    assign w_wr_in_rw     = (r_addr[5:4] == 2'b10) && (r_addr[3:0] != 4'hF);

    always_comb begin
        w_rd_dat = 8'h00;
        case (w_rd_addr)
            6'h00:   w_rd_dat = DEVID_AD;
            6'h01:   w_rd_dat = DEVID_MST;
            6'h02:   w_rd_dat = PARTID;
            6'h0B:   w_rd_dat = {7'd0, r_data_ready};
            6'h0E:   w_rd_dat = r_fx[7:0];
            6'h0F:   w_rd_dat = r_fx[15:8];
            6'h10:   w_rd_dat = r_fy[7:0];
            6'h11:   w_rd_dat = r_fy[15:8];
            6'h12:   w_rd_dat = r_fz[7:0];
            6'h13:   w_rd_dat = r_fz[15:8];
            default: if (w_rd_in_rw) w_rd_dat = r_regs[w_rd_addr[3:0]];
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_IDLE) begin
            if (w_cs_fall) w_next_state = ST_CMD;
        end else if (w_cs_s) begin
            w_next_state = ST_IDLE;
        end else if (w_byte_done) begin
            case (r_state)
                ST_CMD:  w_next_state = (w_byte == CMD_WRITE || w_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
                ST_ADDR: w_next_state = r_is_read ? ST_RD_DATA : ST_WR_DATA;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SCLK_SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SCLK_SYNC_STAGES-2:0], chip_select};
            r_mosi_sync <= {r_mosi_sync[SCLK_SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt    <= 3'd0;
            r_rx         <= 7'd0;
            r_tx         <= 8'h00;
            r_addr       <= 6'd0;
            r_is_read    <= 1'b0;
            r_tx_sample  <= 1'b0;
            r_frame_read <= 1'b0;
            r_srst_pend  <= 1'b0;
            r_miso       <= 1'b0;
            r_int        <= 1'b0;
            r_data_ready <= 1'b0;
            {r_sx, r_sy, r_sz} <= '0;
            {r_fx, r_fy, r_fz} <= '0;
            for (int i = 0; i < 15; i++) r_regs[i] <= (i == 12) ? FILTER_CTL_RST : 8'h00;
        end else begin
            r_int <= r_data_ready & r_regs[10][0];

            if (w_start) begin
                r_bit_cnt    <= 3'd0;
                r_tx         <= 8'h00;
                r_miso       <= 1'b0;
                r_tx_sample  <= 1'b0;
                r_frame_read <= 1'b0;
                r_srst_pend  <= 1'b0;
                {r_fx, r_fy, r_fz} <= {r_sx, r_sy, r_sz};
            end else if (w_deselect) begin
                // A partial byte is simply dropped with the counter.
                r_bit_cnt <= 3'd0;
                r_tx      <= 8'h00;
                r_miso    <= 1'b0;
            end else if (w_active && w_sclk_rise) begin
                r_rx      <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    case (r_state)
                        ST_CMD: r_is_read <= (w_byte == CMD_READ);
                        ST_ADDR: begin
                            if (r_is_read) begin
                                r_tx        <= w_rd_dat;
                                r_miso      <= w_rd_dat[7];
                                r_tx_sample <= w_rd_is_sample;
                                r_addr      <= w_byte[5:0] + 6'd1;
                            end else begin
                                r_addr <= w_byte[5:0];
                            end
                        end
                        ST_WR_DATA: begin
                            if (w_wr_in_rw) r_regs[r_addr[3:0]] <= w_byte;
                            if (r_addr == 6'h1F && w_byte == SOFT_RESET_KEY) r_srst_pend <= 1'b1;
                            r_addr <= r_addr + 6'd1;
                        end
                        ST_RD_DATA: begin
                            // The byte just shifted out counts as read only once complete.
                            if (r_tx_sample) r_frame_read <= 1'b1;
                            r_tx        <= w_rd_dat;
                            r_miso      <= w_rd_dat[7];
                            r_tx_sample <= w_rd_is_sample;
                            r_addr      <= r_addr + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end else if (w_active && w_sclk_fall && r_state == ST_RD_DATA && r_bit_cnt != 3'd0) begin
                // Count 0 means the MSB was already presented at the byte boundary.
                r_miso <= r_tx[3'd7 - r_bit_cnt];
            end

            if (w_deselect && r_frame_read) r_data_ready <= 1'b0;
            if (sample_valid && measuring) begin
                r_sx         <= x_in;
                r_sy         <= y_in;
                r_sz         <= z_in;
                r_data_ready <= 1'b1;
            end
            if (w_deselect && r_srst_pend) begin
                for (int i = 0; i < 15; i++) r_regs[i] <= (i == 12) ? FILTER_CTL_RST : 8'h00;
                {r_sx, r_sy, r_sz} <= '0;
                r_data_ready <= 1'b0;
            end
        end
    end

    assign miso      = r_miso;
    assign interrupt = r_int;
    assign measuring = (r_regs[13][1:0] == 2'b10);

endmodule

// File: tb/tb_acc_spi_responder.sv
// Directed bench for acc_spi_responder with a frame-level register-map model.
module tb_acc_spi_responder;
    logic        clk = 1'b0, rst, sclk, chip_select, mosi, sample_valid;
    logic [15:0] x_in, y_in, z_in;
    logic        miso, interrupt, measuring;

    acc_spi_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .chip_select(chip_select), .mosi(mosi),
        .miso(miso), .x_in(x_in), .y_in(y_in), .z_in(z_in), .sample_valid(sample_valid),
        .interrupt(interrupt), .measuring(measuring)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Model state
    logic [7:0]  m_reg [0:63];
    logic [15:0] m_sx, m_sy, m_sz;
    logic        m_dr, m_settled;
    logic [7:0]  t_tx [0:7];
    logic [7:0]  t_rx [0:7];
    logic [15:0] nx, ny, nz;

    function automatic logic m_meas();
        return m_reg[6'h2D][1:0] == 2'b10;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
        m_reg[6'h2C] = 8'h13;
        m_sx = 0; m_sy = 0; m_sz = 0; m_dr = 0;
    endtask

    function automatic logic [7:0] mread(input logic [5:0] a, input logic [15:0] fx, fy, fz);
        case (a)
            6'h00: return 8'hAD;
            6'h01: return 8'h1D;
            6'h02: return 8'hF2;
            6'h0B: return {7'd0, m_dr};
            6'h0E: return fx[7:0];
            6'h0F: return fx[15:8];
            6'h10: return fy[7:0];
            6'h11: return fy[15:8];
            6'h12: return fz[7:0];
            6'h13: return fz[15:8];
            default: return (a >= 6'h20 && a <= 6'h2E) ? m_reg[a] : 8'h00;
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst && m_settled) begin
                check("int", {15'd0, interrupt}, {15'd0, m_dr & m_reg[6'h2A][0]});
                check("meas", {15'd0, measuring}, {15'd0, m_meas()});
                check("idle_miso", {15'd0, miso}, 16'd0);
            end
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            tick(5);
            rx[7-i] = miso;
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        chip_select = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(3);
        chip_select = 1'b1;
        tick(6);
    endtask

    task automatic pulse_sample(input logic [15:0] x, y, z);
        x_in = x; y_in = y; z_in = z; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        if (m_meas()) begin
            m_sx = x; m_sy = y; m_sz = z; m_dr = 1'b1;
        end
    endtask

    // Frame of n bytes packed MSB-first in b; the last byte carries lastbits bits.
    // A sample pulse (nx/ny/nz) is inserted before byte index mid when mid >= 0.
    task automatic frame(input int n, input logic [63:0] b, input int lastbits, input int mid);
        logic [15:0] fx, fy, fz;
        logic [5:0]  a;
        logic [7:0]  rx, exp;
        logic        touched, srst;
        int          nb;
        for (int k = 0; k < 8; k++) t_tx[k] = b[63-8*k -: 8];
        m_settled = 1'b0;
        cs_low();
        fx = m_sx; fy = m_sy; fz = m_sz;
        touched = 1'b0; srst = 1'b0;
        a = t_tx[1][5:0];
        for (int k = 0; k < n; k++) begin
            if (k == mid) pulse_sample(nx, ny, nz);
            nb = (k == n - 1) ? lastbits : 8;
            spi_bits(t_tx[k], nb, rx);
            t_rx[k] = rx;
            if (nb == 8) begin
                exp = 8'h00;
                if (t_tx[0] == 8'h0B && k >= 2) begin
                    exp = mread(a, fx, fy, fz);
                    if (a >= 6'h0E && a <= 6'h13) touched = 1'b1;
                end
                check("frame_miso", {8'd0, rx}, {8'd0, exp});
                if (t_tx[0] == 8'h0A && k >= 2) begin
                    if (a >= 6'h20 && a <= 6'h2E) m_reg[a] = t_tx[k];
                    if (a == 6'h1F && t_tx[k] == 8'h52) srst = 1'b1;
                end
                if (k >= 2) a = a + 6'd1;
            end
        end
        cs_high();
        if (srst) m_reset();
        else if (touched) m_dr = 1'b0;
        m_settled = 1'b1;
    endtask

    initial begin
        logic [7:0] rx;
        rst = 1'b0; sclk = 1'b0; chip_select = 1'b1; mosi = 1'b0; sample_valid = 1'b0;
        x_in = 0; y_in = 0; z_in = 0; nx = 0; ny = 0; nz = 0;
        m_settled = 1'b0;
        m_reset();
        fork monitor(); join_none
        tick(3);
        check("rst_miso", {15'd0, miso}, 16'd0);
        check("rst_int", {15'd0, interrupt}, 16'd0);
        check("rst_meas", {15'd0, measuring}, 16'd0);
        rst = 1'b1;
        tick(3);
        m_settled = 1'b1;

        // Read ID registers
        frame(5, 64'h0B00_0000_0000_0000, 8, -1);
        check("id_ad", {8'd0, t_rx[2]}, 16'h00AD);
        check("id_1d", {8'd0, t_rx[3]}, 16'h001D);
        check("id_f2", {8'd0, t_rx[4]}, 16'h00F2);

        // Enable measurement and INT1 mapping
        frame(3, 64'h0A2D_0200_0000_0000, 8, -1);
        frame(3, 64'h0A2A_0100_0000_0000, 8, -1);
        check("meas_on", {15'd0, measuring}, 16'd1);
        m_settled = 1'b0;
        pulse_sample(16'h0123, 16'hFFFE, 16'h7FFF);
        tick(1);
        check("int_2clk", {15'd0, interrupt}, 16'd1);
        tick(2);
        m_settled = 1'b1;

        // Burst read of samples with a new sample arriving mid-frame
        nx = 16'h1111; ny = 16'h2222; nz = 16'h3333;
        frame(8, 64'h0B0E_0000_0000_0000, 8, 5);
        check("bx_lo", {8'd0, t_rx[2]}, 16'h0023);
        check("bx_hi", {8'd0, t_rx[3]}, 16'h0001);
        check("by_lo", {8'd0, t_rx[4]}, 16'h00FE);
        check("by_hi", {8'd0, t_rx[5]}, 16'h00FF);
        check("bz_lo", {8'd0, t_rx[6]}, 16'h00FF);
        check("bz_hi", {8'd0, t_rx[7]}, 16'h007F);
        frame(4, 64'h0B0E_0000_0000_0000, 8, -1);
        check("new_x", {t_rx[3], t_rx[2]}, 16'h1111);

        // Writes to read-only space and address wrap
        frame(4, 64'h0A3F_AA55_0000_0000, 8, -1);
        frame(3, 64'h0B00_0000_0000_0000, 8, -1);
        check("ro_ad", {8'd0, t_rx[2]}, 16'h00AD);
        frame(4, 64'h0B3F_0000_0000_0000, 8, -1);
        check("wrap_3f", {8'd0, t_rx[2]}, 16'h0000);
        check("wrap_00", {8'd0, t_rx[3]}, 16'h00AD);

        // Aborted write byte and unknown command
        frame(3, 64'h0A20_FF00_0000_0000, 4, -1);
        frame(4, 64'h0D20_5500_0000_0000, 8, -1);
        frame(3, 64'h0B20_0000_0000_0000, 8, -1);
        check("abort_20", {8'd0, t_rx[2]}, 16'h0000);

        // Hard reset during a read data byte
        m_settled = 1'b0;
        cs_low();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("pre_rst_miso", {15'd0, miso}, 16'd1);
        spi_bits(8'h00, 3, rx);
        rst = 1'b0;
        #1;
        check("hrst_miso", {15'd0, miso}, 16'd0);
        check("hrst_meas", {15'd0, measuring}, 16'd0);
        chip_select = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(3);
        m_reset();
        m_settled = 1'b1;
        frame(5, 64'h0B00_0000_0000_0000, 8, -1);
        check("post_rst_ad", {8'd0, t_rx[2]}, 16'h00AD);

        // Soft reset through 0x1F
        frame(3, 64'h0A2C_5500_0000_0000, 8, -1);
        frame(3, 64'h0A2D_0200_0000_0000, 8, -1);
        frame(4, 64'h0B2C_0000_0000_0000, 8, -1);
        check("pre_srst_2c", {8'd0, t_rx[2]}, 16'h0055);
        frame(3, 64'h0A1F_5200_0000_0000, 8, -1);
        frame(4, 64'h0B2C_0000_0000_0000, 8, -1);
        check("srst_2c", {8'd0, t_rx[2]}, 16'h0013);
        check("srst_2d", {8'd0, t_rx[3]}, 16'h0000);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end
endmodule
